msfsm_hs_pipe: RTL
==================

MSFSM_HS_PIPE -- requirements
Module: msfsm_hs_pipe

Interface
REQ-001 SHALL have parameter N_STAGES, default 3: number of handshake stages (1..16).
REQ-002 SHALL have parameter DW, default 8: data width in bits (>=1).
REQ-003 SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port Ri  in  1  upstream 4-phase request.
REQ-007 SHALL have port Ai  out  1  upstream 4-phase acknowledge.
REQ-008 SHALL have port data  in  DW  upstream data, valid while Ri=1.
REQ-009 SHALL have port Ro  out  1  downstream 4-phase request.
REQ-010 SHALL have port Ao  in  1  downstream 4-phase acknowledge.
REQ-011 SHALL have port q  out  DW  downstream data, stable while Ro=1.
REQ-012 SHALL have port xfer_cnt  out  CNT_W  count of completed downstream transfers.
REQ-013 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-014 SHALL chain N_STAGES identical stages: Ro[k] drives Ri[k+1], Ai[k+1] drives Ao[k], q[k] drives data[k+1]; stage 0 connects to Ri/Ai/data; the last stage connects to Ro/Ao/q.
REQ-015 Each stage SHALL hold a 1-bit full flag, a DW data register, an input-side FSM (IN_IDLE, IN_ACK) and an output-side FSM (OUT_IDLE, OUT_REQ, OUT_RTZ).
REQ-016 Input-side FSM: IN_IDLE with Ri=1 and full=0 -> capture data, set full, Ai<=1, go IN_ACK; IN_ACK with Ri=0 -> Ai<=0, go IN_IDLE.
REQ-017 Ri=1 with full=1 SHALL be held off (Ai stays 0) until full clears.
REQ-018 Output-side FSM: OUT_IDLE with full=1 and Ao=0 -> Ro<=1, go OUT_REQ (on the capture edge if full is being set and Ao=0).
REQ-019 OUT_REQ with Ao=1 -> Ro<=0, clear full, go OUT_RTZ; OUT_RTZ with Ao=0 -> go OUT_IDLE.
REQ-020 On an edge where full clears and Ri=1 in IN_IDLE, the clear SHALL take precedence; capture SHALL occur on the following edge.
REQ-021 Latency: with all stages empty and Ao=0, Ro SHALL rise exactly N_STAGES edges after the first edge sampling Ri=1.
REQ-022 Steady-state throughput SHALL be one transfer per 4 cycles when the environment responds in one cycle; the pipeline holds up to N_STAGES items.
REQ-023 xfer_cnt SHALL increment by 1 on each last-stage OUT_REQ->OUT_RTZ transition and SHALL wrap modulo 2^CNT_W.
REQ-024 q SHALL change only on a capture edge of the last stage.

Reset
REQ-025 Asserting reset SHALL immediately force Ai=0, Ro=0, q=0, xfer_cnt=0, err=0, all full flags to 0, and all FSMs to IN_IDLE/OUT_IDLE, including mid-handshake.
REQ-026 After reset deasserts, a stage SHALL NOT capture until Ri has been sampled 0 at least once, which prevents acceptance of a stale request.

Configuration
REQ-027 With macro MSFSM_PROTO_ERR_EN defined, err SHALL be set sticky on: Ri falling while the stage-0 input FSM is in IN_IDLE with Ri previously 1 and no ack (withdrawn request); Ao=1 sampled in last-stage OUT_IDLE; Ao falling in last-stage OUT_REQ.
REQ-028 Without MSFSM_PROTO_ERR_EN, err SHALL be tied 0 and no checking logic SHALL be synthesised.

Structure
REQ-029 Package msfsm_hs_pkg SHALL hold the input/output FSM state enums and the N_STAGES range limits.
REQ-030 A single sub-module msfsm_hs_stage SHALL implement one stage; msfsm_hs_pipe SHALL instantiate it N_STAGES times and hold xfer_cnt and err.

Verification
REQ-031 N=3, DW=8, Ao tied to Ro after 1 cycle: send 0xA5 -> Ro rises 3 edges after Ri, q=0xA5, xfer_cnt=1.
REQ-032 Ao held 0, send 0x01..0x04 -> 3 accepted (Ai pulses 3 times), the 4th Ri is held off; release Ao -> q sequence 01,02,03,04 in order.
REQ-033 Assert reset with 2 items in flight -> all outputs 0 the same cycle; after release, Ri held 1 from before reset is not captured until it has toggled low.
REQ-034 CNT_W=4, 17 transfers -> xfer_cnt=1 (wrap).
REQ-035 With MSFSM_PROTO_ERR_EN: Ao=1 while Ro=0 -> err=1, persists until reset; same stimulus without macro -> err=0.
REQ-036 N=1: Ao driven high in the same cycle Ri falls -> no lost or duplicated item, xfer_cnt increments exactly once.

Source files
------------

// File: rtl/msfsm_hs_pkg.sv
// Shared types and limits for the 4-phase handshake pipeline.
package msfsm_hs_pkg;

    localparam int N_STAGES_MIN = 1;
    localparam int N_STAGES_MAX = 16;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_RTZ  = 2'd2
    } out_state_e;

endpackage

// File: rtl/msfsm_hs_stage.sv
// One 4-phase handshake stage: input FSM captures, output FSM forwards.
// Protocol checks exist only when MSFSM_PROTO_ERR_EN is defined.
//
// state    | meaning
// IN_IDLE  | waiting for a request while empty
// IN_ACK   | item captured, Ai high until upstream returns Ri to zero
// OUT_IDLE | nothing offered downstream
// OUT_REQ  | Ro high, waiting for downstream acknowledge
// OUT_RTZ  | Ro low, waiting for downstream acknowledge to return to zero
module msfsm_hs_stage
    import msfsm_hs_pkg::*;
#(
    parameter int DW = 8
`ifdef MSFSM_PROTO_ERR_EN
    , parameter bit CHK_IN  = 1'b0
    , parameter bit CHK_OUT = 1'b0
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ri,
    output logic          ai,
    input  logic [DW-1:0] d,
    output logic          ro,
    input  logic          ao,
    output logic [DW-1:0] q
`ifdef MSFSM_PROTO_ERR_EN
    , output logic        viol
`endif
);

    in_state_e  in_st;
    out_state_e out_st;
    logic       full;
    logic       armed;
    logic       capture;

    // armed blocks a request left high across reset from being taken as new
    assign capture = (in_st == IN_IDLE) && ri && !full && armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_st  <= IN_IDLE;
            out_st <= OUT_IDLE;
            full   <= 1'b0;
            armed  <= 1'b0;
            ai     <= 1'b0;
            ro     <= 1'b0;
            q      <= '0;
        end else begin
            if (!ri)
                armed <= 1'b1;

            case (in_st)
                IN_IDLE: if (capture) begin
                    q     <= d;
                    ai    <= 1'b1;
                    in_st <= IN_ACK;
                end
                IN_ACK: if (!ri) begin
                    ai    <= 1'b0;
                    in_st <= IN_IDLE;
                end
                default: in_st <= IN_IDLE;
            endcase

            case (out_st)
                OUT_IDLE: if ((full || capture) && !ao) begin
                    ro     <= 1'b1;
                    out_st <= OUT_REQ;
                end
                OUT_REQ: if (ao) begin
                    ro     <= 1'b0;
                    out_st <= OUT_RTZ;
                end
                OUT_RTZ: if (!ao)
                    out_st <= OUT_IDLE;
                default: out_st <= OUT_IDLE;
            endcase

            // capture needs full=0 and release needs OUT_REQ (full=1): never both
            if (capture)
                full <= 1'b1;
            else if ((out_st == OUT_REQ) && ao)
                full <= 1'b0;
        end
    end

`ifdef MSFSM_PROTO_ERR_EN
    logic ri_prev;
    logic ao_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ri_prev <= 1'b0;
            ao_prev <= 1'b0;
        end else begin
            ri_prev <= ri;
            ao_prev <= ao;
        end
    end

    assign viol = (CHK_IN && (in_st == IN_IDLE) && ri_prev && !ri) ||
                  (CHK_OUT && (((out_st == OUT_IDLE) && ao) ||
                               ((out_st == OUT_REQ) && ao_prev && !ao)));
`endif

endmodule

// File: rtl/msfsm_hs_pipe.sv
// Chain of N_STAGES 4-phase handshake stages with transfer counter and
// sticky protocol error flag (checking enabled by MSFSM_PROTO_ERR_EN).
module msfsm_hs_pipe
    import msfsm_hs_pkg::*;
#(
    parameter int N_STAGES = 3,
    parameter int DW       = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ri,
    output logic             Ai,
    input  logic [DW-1:0]    data,
    output logic             Ro,
    input  logic             Ao,
    output logic [DW-1:0]    q,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err
);

    if (N_STAGES < N_STAGES_MIN || N_STAGES > N_STAGES_MAX) begin : g_bad_n
        $error("msfsm_hs_pipe: N_STAGES out of range");
    end

    // link k sits in front of stage k; link N_STAGES is the downstream port
    logic [N_STAGES:0] req;
    logic [N_STAGES:0] ack;
    logic [DW-1:0]     dat [0:N_STAGES];

    assign req[0]        = Ri;
    assign Ai            = ack[0];
    assign dat[0]        = data;
    assign Ro            = req[N_STAGES];
    assign ack[N_STAGES] = Ao;
    assign q             = dat[N_STAGES];

`ifdef MSFSM_PROTO_ERR_EN
    logic [N_STAGES-1:0] viol;
`endif

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        msfsm_hs_stage #(
            .DW(DW)
`ifdef MSFSM_PROTO_ERR_EN
            , .CHK_IN(k == 0)
            , .CHK_OUT(k == N_STAGES - 1)
`endif
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .ri   (req[k]),
            .ai   (ack[k]),
            .d    (dat[k]),
            .ro   (req[k+1]),
            .ao   (ack[k+1]),
            .q    (dat[k+1])
`ifdef MSFSM_PROTO_ERR_EN
            , .viol(viol[k])
`endif
        );
    end

    // last stage is in OUT_REQ exactly while Ro is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xfer_cnt <= '0;
        else if (Ro && Ao)
            xfer_cnt <= xfer_cnt + CNT_W'(1);
    end

`ifdef MSFSM_PROTO_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (|viol)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
